// File: rtl/lcd_line_driver_pkg.sv
// lcd_line_driver_pkg: state encoding, HD44780 command bytes and row helpers
package lcd_line_driver_pkg;

    typedef enum logic [2:0] {PWR_WAIT, INIT, CLR_WAIT, ADDR1, ROW1, ADDR2, ROW2} state_t;

    typedef enum logic [1:0] {SETUP, PULSE, HOLD} phase_t;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ROW1     = 8'h80;
    localparam logic [7:0] CMD_ROW2     = 8'hC0;

    localparam logic [127:0] BLANK_ROW = {16{8'h20}};

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        return i == 2'd0 ? CMD_FUNC_SET : i == 2'd1 ? CMD_DISP_ON : i == 2'd2 ? CMD_ENTRY : CMD_CLEAR;
    endfunction

    // char 0 sits in the top byte of a row
    function automatic logic [7:0] row_char(input logic [127:0] row, input logic [3:0] i);
        logic [127:0] s;
        s = row << {i, 3'b000};
        return s[127:120];
    endfunction

endpackage

// File: rtl/lcd_line_driver_tick.sv
// lcd_tick_gen: free-running divider producing a one-clk tick every TICK_DIV clocks
module lcd_tick_gen #(
    parameter int TICK_DIV = 100
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt;

    assign tick = cnt == CW'(TICK_DIV - 1);

    // count 0..TICK_DIV-1 and wrap on the tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else cnt <= tick ? '0 : cnt + CW'(1);
    end
endmodule

// File: rtl/lcd_line_driver.sv
// lcd_line_driver: powers up an HD44780 in 8-bit mode and refreshes two 16-char rows forever
module lcd_line_driver
    import lcd_line_driver_pkg::*;
#(
    parameter int TICK_DIV  = 100,
    parameter int PWR_TICKS = 20000,
    parameter int CLR_TICKS = 2000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] line1,
    input  logic [127:0] line2,
    output logic         lcd_e,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic [7:0]   lcd_data,
    output logic         init_done,
    output logic         frame_done
);
    localparam int WAIT_MAX = PWR_TICKS > CLR_TICKS ? PWR_TICKS : CLR_TICKS;
    localparam int WW = $clog2(WAIT_MAX + 1);

    state_t         state;
    phase_t         phase;
    logic [WW-1:0]  wcnt;
    logic [3:0]     idx;
    logic [127:0]   snap1;
    logic [127:0]   snap2;
    logic           tick;
    logic           last_char;

    lcd_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign lcd_rw    = 1'b0;
    assign last_char = idx == 4'd15;

    // sequencer: each write is SETUP/PULSE/HOLD ticks; the next byte is loaded as HOLD ends
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= PWR_WAIT;
            phase      <= SETUP;
            wcnt       <= '0;
            idx        <= '0;
            snap1      <= BLANK_ROW;
            snap2      <= BLANK_ROW;
            lcd_e      <= 1'b0;
            lcd_rs     <= 1'b0;
            lcd_data   <= 8'h00;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (tick) begin
                case (state)
                    PWR_WAIT: begin
                        if (wcnt == WW'(PWR_TICKS - 1)) begin
                            wcnt     <= '0;
                            state    <= INIT;
                            lcd_rs   <= 1'b0;
                            lcd_data <= CMD_FUNC_SET;
                        end else begin
                            wcnt <= wcnt + WW'(1);
                        end
                    end
                    CLR_WAIT: begin
                        if (wcnt == WW'(CLR_TICKS - 1)) begin
                            wcnt      <= '0;
                            init_done <= 1'b1;
                            state     <= ADDR1;
                            snap1     <= line1;
                            snap2     <= line2;
                            lcd_rs    <= 1'b0;
                            lcd_data  <= CMD_ROW1;
                        end else begin
                            wcnt <= wcnt + WW'(1);
                        end
                    end
                    default: begin
                        case (phase)
                            SETUP: begin
                                lcd_e <= 1'b1;
                                phase <= PULSE;
                            end
                            PULSE: begin
                                lcd_e <= 1'b0;
                                phase <= HOLD;
                            end
                            default: begin
                                phase <= SETUP;
                                case (state)
                                    INIT: begin
                                        if (idx == 4'd3) begin
                                            idx   <= '0;
                                            state <= CLR_WAIT;
                                        end else begin
                                            idx      <= idx + 4'd1;
                                            lcd_data <= init_cmd(idx[1:0] + 2'd1);
                                        end
                                    end
                                    ADDR1: begin
                                        state    <= ROW1;
                                        lcd_rs   <= 1'b1;
                                        lcd_data <= row_char(snap1, 4'd0);
                                    end
                                    ROW1: begin
                                        if (last_char) begin
                                            idx      <= '0;
                                            state    <= ADDR2;
                                            lcd_rs   <= 1'b0;
                                            lcd_data <= CMD_ROW2;
                                        end else begin
                                            idx      <= idx + 4'd1;
                                            lcd_data <= row_char(snap1, idx + 4'd1);
                                        end
                                    end
                                    ADDR2: begin
                                        state    <= ROW2;
                                        lcd_rs   <= 1'b1;
                                        lcd_data <= row_char(snap2, 4'd0);
                                    end
                                    default: begin
                                        if (last_char) begin
                                            idx        <= '0;
                                            state      <= ADDR1;
                                            frame_done <= 1'b1;
                                            snap1      <= line1;
                                            snap2      <= line2;
                                            lcd_rs     <= 1'b0;
                                            lcd_data   <= CMD_ROW1;
                                        end else begin
                                            idx      <= idx + 4'd1;
                                            lcd_data <= row_char(snap2, idx + 4'd1);
                                        end
                                    end
                                endcase
                            end
                        endcase
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lcd_line_driver.sv
// tb_lcd_line_driver: random-text refresh bench against a write-list reference model
module tb_lcd_line_driver;
    localparam int TD = 2;
    localparam int PWR = 4;
    localparam int CLR = 3;
    localparam int INIT_CYC = TD * (PWR + 4 * 3 + CLR);
    localparam int FRAME_CYC = TD * 34 * 3;

    logic         clk;
    logic         rst;
    logic [127:0] line1;
    logic [127:0] line2;
    logic         lcd_e;
    logic         lcd_rs;
    logic         lcd_rw;
    logic [7:0]   lcd_data;
    logic         init_done;
    logic         frame_done;

    int checks;
    int errors;
    int cyc;
    int fd_count;
    int last_fd;
    int hi;
    int stab;
    int hold_left;
    logic prev_e;
    logic [8:0] bus;
    logic [8:0] prev_bus;
    logic [8:0] held;
    logic [8:0] exp_q[$];

    lcd_line_driver #(.TICK_DIV(TD), .PWR_TICKS(PWR), .CLR_TICKS(CLR)) dut (
        .clk        (clk),
        .rst        (rst),
        .line1      (line1),
        .line2      (line2),
        .lcd_e      (lcd_e),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_data   (lcd_data),
        .init_done  (init_done),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int bnd(input int k);
        return INIT_CYC + FRAME_CYC * k;
    endfunction

    function automatic logic [127:0] rand_row();
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'($urandom_range(32, 126));
        return r;
    endfunction

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
    endtask

    task automatic push_frame();
        exp_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, line1[127 - 8*i -: 8]});
        exp_q.push_back({1'b0, 8'hC0});
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, line2[127 - 8*i -: 8]});
    endtask

    function automatic bit at_boundary_minus1(input int c);
        return c >= INIT_CYC - 1 && (c - (INIT_CYC - 1)) % FRAME_CYC == 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else cyc <= cyc + 1;
    end

    // bus monitor: strobe shape, data stability, write order and status flags
    always @(negedge clk) begin
        bus = {lcd_rs, lcd_data};
        if (!rst) begin
            prev_e = 1'b0;
            hi = 0;
            stab = 0;
            hold_left = 0;
            prev_bus = bus;
            last_fd = -1;
        end else begin
            stab = bus == prev_bus ? stab + 1 : 0;
            check("init_done", init_done, cyc >= INIT_CYC);
            check("frame_done", frame_done, cyc > INIT_CYC && (cyc - INIT_CYC) % FRAME_CYC == 0);
            if (frame_done) begin
                fd_count++;
                if (last_fd >= 0) check("fd_gap", cyc - last_fd, FRAME_CYC);
                last_fd = cyc;
            end
            if (lcd_e && !prev_e) begin
                check("setup_stable", stab >= 2, 1);
                check("rw", lcd_rw, 0);
                check("q_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("bus", bus, exp_q.pop_front());
                held = bus;
                hi = 0;
            end
            if (lcd_e) begin
                hi++;
                check("pulse_stable", bus, held);
            end else if (prev_e) begin
                check("e_width", hi, 2);
                check("hold_stable", bus, held);
                hold_left = 1;
            end else if (hold_left > 0) begin
                check("hold_stable", bus, held);
                hold_left--;
            end
            prev_e = lcd_e;
            prev_bus = bus;
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        fd_count = 0;
        rst = 1'b0;
        line1 = "PRESS * TO START";
        line2 = "MONEY: 01000    ";
        repeat (3) @(negedge clk);
        check("rst_e", lcd_e, 0);
        check("rst_rs", lcd_rs, 0);
        check("rst_rw", lcd_rw, 0);
        check("rst_data", lcd_data, 8'h00);
        check("rst_init_done", init_done, 0);
        check("rst_frame_done", frame_done, 0);
        rst = 1'b1;
        push_init();
        while (cyc != bnd(3) + 158) begin
            @(negedge clk);
            if (cyc == bnd(0) + 38) line1 = {16{8'h58}};
            else if (cyc > bnd(1) && $urandom_range(0, 99) == 0) begin
                line1 = rand_row();
                line2 = rand_row();
            end
            if (at_boundary_minus1(cyc)) push_frame();
        end
        check("e_before_rst", lcd_e, 1);
        check("fd_count", fd_count, 3);
        #1 rst = 1'b0;
        exp_q.delete();
        #1;
        check("async_e", lcd_e, 0);
        check("async_rs", lcd_rs, 0);
        check("async_data", lcd_data, 8'h00);
        check("async_init_done", init_done, 0);
        check("async_frame_done", frame_done, 0);
        repeat (4) begin
            @(negedge clk);
            check("rst_hold_e", lcd_e, 0);
            check("rst_hold_init_done", init_done, 0);
        end
        rst = 1'b1;
        push_init();
        while (cyc < bnd(1) - 2) begin
            @(negedge clk);
            if (at_boundary_minus1(cyc)) push_frame();
        end
        check("q_drained", exp_q.size(), 0);
        check("fd_total", fd_count, 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcd_line_driver.md
LCD_LINE_DRIVER -- requirements
Module: lcd_line_driver

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100; clk cycles per LCD timing tick, >=2.
REQ-002 SHALL have parameter PWR_TICKS, default 20000; power-on wait in ticks before the first command.
REQ-003 SHALL have parameter CLR_TICKS, default 2000; wait in ticks after the clear-display command.
REQ-004 clk  in  1  single system clock; all logic on posedge clk.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 line1  in  128  ASCII row 1; char 0 = bits [127:120], char 15 = bits [7:0].
REQ-007 line2  in  128  ASCII row 2; same packing as line1.
REQ-008 lcd_e  out  1  HD44780 enable strobe.
REQ-009 lcd_rs  out  1  0 = command, 1 = character data.
REQ-010 lcd_rw  out  1  tied 0 (write only).
REQ-011 lcd_data  out  8  8-bit bus value.
REQ-012 init_done  out  1  high once the init sequence completes; stays high until reset.
REQ-013 frame_done  out  1  one-clk pulse after the last char of row 2 is written.

Function
REQ-014 Tick counter SHALL count 0..TICK_DIV-1 and assert tick for one clk when the count is TICK_DIV-1; it SHALL free-run from reset.
REQ-015 Every bus write SHALL take 3 ticks:
- SETUP: lcd_e=0, rs/data valid.
- PULSE: lcd_e=1.
- HOLD: lcd_e=0.
- rs and data SHALL stay stable across all 3 ticks.
REQ-016 States SHALL be PWR_WAIT, INIT, CLR_WAIT, ADDR1, ROW1, ADDR2, ROW2.
REQ-017 PWR_WAIT SHALL last PWR_TICKS ticks, then go to INIT.
REQ-018 INIT SHALL write commands 0x38, 0x0C, 0x06, 0x01 in that order, then go to CLR_WAIT.
REQ-019 CLR_WAIT SHALL last CLR_TICKS ticks, then set init_done=1 and go to ADDR1.
REQ-020 ADDR1 SHALL do the following, then go to ROW1:
- Snapshot line1 and line2 into internal 128-bit registers on the clk it is entered.
- Write command 0x80.
REQ-021 ROW1 SHALL write snapshot row-1 chars 0..15 (rs=1) with a 4-bit index, then go to ADDR2.
REQ-022 ADDR2 SHALL write command 0xC0, then go to ROW2.
REQ-023 ROW2 SHALL write snapshot row-2 chars 0..15, pulse frame_done on the clk ROW2 exits, then return to ADDR1.
REQ-024 line1/line2 changes after a snapshot SHALL NOT affect the frame in progress; they SHALL appear in the next frame.
REQ-025 Char index SHALL wrap 15 -> 0 only on a state transition; no write beyond 16 chars per row.
REQ-026 Wait counters SHALL be wide enough for max(PWR_TICKS, CLR_TICKS) with no overflow.
REQ-027 A frame SHALL take exactly 34 writes = 102 ticks from ADDR1 entry to frame_done.

Reset
REQ-028 While rst=0, outputs SHALL be: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, init_done=0, frame_done=0; snapshots SHALL be 0x20 in every byte.
REQ-029 While rst=0, the state SHALL be PWR_WAIT and all counters 0.
REQ-030 Reset mid-write SHALL drop lcd_e asynchronously; after release the full power-on/init sequence SHALL repeat.

Structure
REQ-031 A shared package SHALL hold the state encoding and command constants 0x38, 0x0C, 0x06, 0x01, 0x80, 0xC0.
REQ-032 The tick counter SHALL be sub-module lcd_tick_gen (clk, rst, tick), parameterised by TICK_DIV.

Verification
All scenarios use TICK_DIV=2, PWR_TICKS=4, CLR_TICKS=3.
REQ-033 Release reset -> after 4 ticks the bus shows 0x38, 0x0C, 0x06, 0x01 with rs=0, then 3 idle ticks, then init_done=1.
REQ-034 line1="PRESS * TO START", line2="MONEY: 01000    " -> bus sequence is 0x80, 0x50 0x52 0x45 ... 0x54, 0xC0, 0x4D ... 0x20; rs=1 on chars only; frame_done pulses once.
REQ-035 Change line1 to all "X" during ROW1 char 5 -> current frame still shows the original string; the next frame shows 16 x 0x58.
REQ-036 Each write -> lcd_e high for exactly 2 clk (1 tick), with data stable 2 clk before and 2 clk after.
REQ-037 Assert rst during ROW2 char 8 -> lcd_e=0 in the same cycle, no frame_done; after release, init_done=0 until the init sequence repeats.
REQ-038 Consecutive frame_done pulses -> exactly 204 clk apart.
